// File: rtl/mlp_layer_ctrl.sv
// Sequencer for one fully-connected MLP layer. It streams a captured input vector into the
// layer, fires the ReLU/clip register once the MAC has settled, and arbitrates weight writes.
module mlp_layer_ctrl #(
    parameter int N_INPUTS  = 2,
    parameter int N_NEURONS = 4,
    parameter int IN_WIDTH  = 16,
    parameter int WGT_WIDTH = 16,
    parameter int MAC_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_start,
    input  logic [N_INPUTS*IN_WIDTH-1:0]  in_flat,
    output logic                          busy,
    output logic                          done,
    input  logic                          host_wr_en,
    input  logic [$clog2(N_NEURONS)-1:0]  host_wr_row,
    input  logic [$clog2(N_INPUTS)-1:0]   host_wr_col,
    input  logic [WGT_WIDTH-1:0]          host_wr_weight,
    output logic                          wr_err,
    output logic                          wr_en,
    output logic [$clog2(N_NEURONS)-1:0]  wr_row,
    output logic [$clog2(N_INPUTS)-1:0]   wr_col,
    output logic [WGT_WIDTH-1:0]          wr_weight,
    output logic signed [IN_WIDTH-1:0]    input_value,
    output logic [$clog2(N_INPUTS)-1:0]   input_index,
    output logic                          start,
    output logic                          valid,
    output logic                          relu_en
);
    localparam int COL_W = $clog2(N_INPUTS);
    localparam int LAT_W = $clog2(MAC_LAT + 1);
    localparam logic [COL_W-1:0] LAST_IDX   = COL_W'(N_INPUTS - 1);
    localparam logic [LAT_W-1:0] LAST_DRAIN = LAT_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, RELU, DONE} state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] snapshot [N_INPUTS];
    logic [LAT_W-1:0]    drain_cnt;

    // The weight port belongs to the host whenever no inference is reading it.
    assign wr_en     = host_wr_en & ~busy;
    assign wr_row    = host_wr_row;
    assign wr_col    = host_wr_col;
    assign wr_weight = host_wr_weight;

    // NOTE: all state here is registered with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_err      <= 1'b0;
            start       <= 1'b0;
            valid       <= 1'b0;
            relu_en     <= 1'b0;
            input_index <= '0;
            input_value <= '0;
            drain_cnt   <= '0;
            // NOTE: the snapshot is a small register array, not a RAM, so it is cleared
            // explicitly; no stale vector survives a reset.
            for (int k = 0; k < N_INPUTS; k++) snapshot[k] <= '0;
        end else begin
            start   <= 1'b0;
            valid   <= 1'b0;
            relu_en <= 1'b0;
            done    <= 1'b0;
            wr_err  <= host_wr_en & busy;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (in_start) begin
                        for (int k = 0; k < N_INPUTS; k++)
                            snapshot[k] <= in_flat[k*IN_WIDTH +: IN_WIDTH];
                        input_index <= '0;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    // Issue trails the index by one cycle to line up with the synchronous weight read.
                    start       <= (input_index == '0);
                    valid       <= (input_index != '0);
                    input_value <= $signed(snapshot[input_index]);
                    if (input_index == LAST_IDX) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        input_index <= input_index + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        relu_en <= 1'b1;
                        state   <= RELU;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                RELU: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
